mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 20 ++
 rtl/mem_loader_if.sv | 31 +++
 rtl/mem_loader_byte_pair.sv | 25 ++
 rtl/mem_loader.sv | 88 ++++++++
 tb/tb_mem_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the serial-to-memory frame loader.
package mem_loader_pkg;

  // Frame parser states, in the order the frame fields arrive.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_LO = 4'd1,
    ADDR_HI = 4'd2,
    CNT_LO  = 4'd3,
    CNT_HI  = 4'd4,
    DATA_LO = 4'd5,
    DATA_HI = 4'd6,
    WRITE   = 4'd7,
    DONE    = 4'd8
  } state_t;

  // Header length in bytes: base address (2) plus word count (2).
  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and data-memory write port of the loader.
// Handshake: the byte source asserts rx_valid for exactly the cycles in
// which rx_data carries a new byte. There is no ready; the loader consumes
// a byte only in its header/data states, and the source keeps at least two
// cycles between a word's hi byte and the next lo byte. write_en is a
// one-cycle strobe with addr/datain valid in that same cycle. start is a
// one-cycle pulse that is honoured only while the loader is idle.
interface mem_loader_if #(parameter int N = 16);
  import mem_loader_pkg::*;

  logic         start;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         write_en;
  logic [N-1:0] addr;
  logic [N-1:0] datain;
  logic         busy;
  logic         done;
  state_t       state;

  // master: byte source / memory observer; slave: the loader itself.
  modport master (
    output start, rx_valid, rx_data,
    input  write_en, addr, datain, busy, done, state
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output write_en, addr, datain, busy, done, state
  );
endinterface

// File: rtl/mem_loader_byte_pair.sv
// Assembles a 16-bit little-endian field from two successive bytes.
// The lo byte is held in a register; pair combines it with the byte on
// byte_in, so pair is meaningful in the cycle the hi byte is accepted.
module byte_pair (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_lo,
  input  logic [7:0]  byte_in,
  output logic [15:0] pair
);

  logic [7:0] lo_q;

  // Capture the lo byte of the field currently being received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 8'h00;
    end else if (load_lo) begin
      lo_q <= byte_in;
    end
  end

  assign pair = {byte_in, lo_q};

endmodule

// File: rtl/mem_loader.sv
// Frame loader: parses base address, word count and data words from a
// byte stream and issues one data-memory write per word.
// N (9..16) is the memory address and data width; the 16-bit base address
// and data words are truncated to N bits, the count is kept at 16 bits.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_loader_if.slave bus
);

  state_t       state_q, state_d;
  logic [N-1:0] addr_q;
  logic [N-1:0] datain_q;
  logic [15:0]  count_q;
  logic [15:0]  pair;
  logic         load_lo;
  logic         take_hi;

  // Bytes are consumed only in the header/data states on rx_valid cycles.
  assign load_lo = bus.rx_valid &&
                   (state_q == ADDR_LO || state_q == CNT_LO || state_q == DATA_LO);
  assign take_hi = bus.rx_valid &&
                   (state_q == ADDR_HI || state_q == CNT_HI || state_q == DATA_HI);

  byte_pair u_byte_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_lo (load_lo),
    .byte_in (bus.rx_data),
    .pair    (pair)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; header/data states hold until a byte arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)    state_d = ADDR_LO;
      ADDR_LO: if (bus.rx_valid) state_d = ADDR_HI;
      ADDR_HI: if (bus.rx_valid) state_d = CNT_LO;
      CNT_LO:  if (bus.rx_valid) state_d = CNT_HI;
      CNT_HI:  if (bus.rx_valid) state_d = (pair == 16'd0) ? DONE : DATA_LO;
      DATA_LO: if (bus.rx_valid) state_d = DATA_HI;
      DATA_HI: if (bus.rx_valid) state_d = WRITE;
      // count_q still holds the pre-decrement value here.
      WRITE:   state_d = (count_q != 16'd1) ? DATA_LO : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, remaining-count and write-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      datain_q <= '0;
      count_q  <= 16'd0;
    end else begin
      if (take_hi && state_q == ADDR_HI) addr_q   <= pair[N-1:0];
      if (take_hi && state_q == CNT_HI)  count_q  <= pair;
      if (take_hi && state_q == DATA_HI) datain_q <= pair[N-1:0];
      if (state_q == WRITE) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q - 16'd1;
      end
    end
  end

  assign bus.write_en = (state_q == WRITE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.addr     = addr_q;
  assign bus.datain   = datain_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: one N=16 and one N=12 instance sharing
// the byte stream; start is steered to the instance under test.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       sel;      // 0: N=16 instance, 1: N=12 instance

  int errors;
  int checks;
  int extra16;
  int extra12;

  logic [31:0] exp16_q[$];
  logic [31:0] exp12_q[$];

  mem_loader_if #(.N(16)) bus16 ();
  mem_loader_if #(.N(12)) bus12 ();

  assign bus16.start    = start & ~sel;
  assign bus12.start    = start & sel;
  assign bus16.rx_valid = rx_valid;
  assign bus12.rx_valid = rx_valid;
  assign bus16.rx_data  = rx_data;
  assign bus12.rx_data  = rx_data;

  mem_loader #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mem_loader #(.N(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  logic        cur_we;
  logic        cur_busy;
  logic        cur_done;
  logic [15:0] cur_addr;
  logic [15:0] cur_datain;
  logic [3:0]  cur_state;

  assign cur_we     = sel ? bus12.write_en : bus16.write_en;
  assign cur_busy   = sel ? bus12.busy     : bus16.busy;
  assign cur_done   = sel ? bus12.done     : bus16.done;
  assign cur_addr   = sel ? 16'(bus12.addr)   : bus16.addr;
  assign cur_datain = sel ? 16'(bus12.datain) : bus16.datain;
  assign cur_state  = sel ? bus12.state : bus16.state;

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write strobe seen mid-cycle is matched in order.
  always @(negedge clk) begin
    if (bus16.write_en === 1'b1) begin
      if (exp16_q.size() > 0) check("w16", {bus16.addr, bus16.datain}, exp16_q.pop_front());
      else extra16++;
    end
    if (bus12.write_en === 1'b1) begin
      if (exp12_q.size() > 0) check("w12", {16'(bus12.addr), 16'(bus12.datain)}, exp12_q.pop_front());
      else extra12++;
    end
  end

  // Driver tasks: all are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
  endtask

  // Gap of five idle cycles with a stray start pulse in the middle.
  task automatic send_gapped(input logic [7:0] b);
    idle(2);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(2);
    send_byte(b);
  endtask

  // One data word; leaves one cycle after the write strobe.
  task automatic send_word(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo);
    send_byte(hi);
    check({tag, "_we"}, 32'(cur_we), 32'd1);
    idle(1);
    check({tag, "_we_off"}, 32'(cur_we), 32'd0);
  endtask

  task automatic frame_end(input string tag);
    check({tag, "_left16"}, exp16_q.size(), 0);
    check({tag, "_extra16"}, extra16, 0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    extra16  = 0;
    extra12  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sel      = 1'b0;

    // Reset state.
    idle(3);
    check("rst_we16",   32'(bus16.write_en), 32'd0);
    check("rst_addr16", 32'(bus16.addr),     32'd0);
    check("rst_din16",  32'(bus16.datain),   32'd0);
    check("rst_busy16", 32'(bus16.busy),     32'd0);
    check("rst_done16", 32'(bus16.done),     32'd0);
    check("rst_st16",   32'(bus16.state),    32'(IDLE));
    check("rst_busy12", 32'(bus12.busy),     32'd0);
    rst_n = 1'b1;
    idle(2);

    // N=16: base 0x1000, four words 1..4.
    exp16_q.push_back(32'h1000_0001);
    exp16_q.push_back(32'h1001_0002);
    exp16_q.push_back(32'h1002_0003);
    exp16_q.push_back(32'h1003_0004);
    pulse_start();
    check("a_st_addr_lo", 32'(cur_state), 32'(ADDR_LO));
    check("a_busy", 32'(cur_busy), 32'd1);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h04); send_byte(8'h00);
    check("a_st_data_lo", 32'(cur_state), 32'(DATA_LO));
    for (int i = 1; i <= 4; i++) send_word("a", 8'(i), 8'h00);
    check("a_done", 32'(cur_done), 32'd1);
    check("a_done_busy", 32'(cur_busy), 32'd1);
    idle(1);
    check("a_done_off", 32'(cur_done), 32'd0);
    check("a_busy_off", 32'(cur_busy), 32'd0);
    check("a_addr_hold", 32'(cur_addr), 32'h1004);
    frame_end("a");

    // N=12: base 0xFFF wraps to 0, data truncated to 12 bits.
    sel = 1'b1;
    exp12_q.push_back(32'h0FFF_0BCD);
    exp12_q.push_back(32'h0000_0123);
    pulse_start();
    send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h02); send_byte(8'h00);
    send_word("b0", 8'hCD, 8'hAB);
    send_word("b1", 8'h23, 8'h01);
    check("b_done", 32'(cur_done), 32'd1);
    check("b_addr_wrap", 32'(cur_addr), 32'h0001);
    check("b_din_hold", 32'(cur_datain), 32'h0123);
    idle(1);
    check("b_busy_off", 32'(cur_busy), 32'd0);
    check("b_left12", exp12_q.size(), 0);
    check("b_extra12", extra12, 0);
    sel = 1'b0;
    check("b_n16_quiet", 32'(bus16.busy), 32'd0);

    // Zero count: done right after the count hi byte, no write.
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("z_done", 32'(cur_done), 32'd1);
    check("z_we", 32'(cur_we), 32'd0);
    idle(1);
    check("z_busy_off", 32'(cur_busy), 32'd0);
    check("z_addr", 32'(cur_addr), 32'h0000);
    frame_end("z");

    // Gapped bytes with start pulses mid-frame.
    exp16_q.push_back(32'h1000_0001);
    exp16_q.push_back(32'h1001_0002);
    exp16_q.push_back(32'h1002_0003);
    exp16_q.push_back(32'h1003_0004);
    pulse_start();
    send_gapped(8'h00); send_gapped(8'h10); send_gapped(8'h04); send_gapped(8'h00);
    check("g_st_data_lo", 32'(cur_state), 32'(DATA_LO));
    for (int i = 1; i <= 4; i++) begin
      send_gapped(8'(i));
      send_gapped(8'h00);
      check("g_we", 32'(cur_we), 32'd1);
    end
    idle(1);
    check("g_done", 32'(cur_done), 32'd1);
    idle(1);
    check("g_busy_off", 32'(cur_busy), 32'd0);
    frame_end("g");

    // Reset after the second data lo byte.
    exp16_q.push_back(32'h1000_0001);
    pulse_start();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h04); send_byte(8'h00);
    send_word("r0", 8'h01, 8'h00);
    send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    check("r_we",   32'(cur_we),     32'd0);
    check("r_addr", 32'(cur_addr),   32'd0);
    check("r_din",  32'(cur_datain), 32'd0);
    check("r_busy", 32'(cur_busy),   32'd0);
    check("r_done", 32'(cur_done),   32'd0);
    check("r_st",   32'(cur_state),  32'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h00);
    check("r_no_restart", 32'(cur_state), 32'(IDLE));
    frame_end("r");
    exp16_q.push_back(32'h2000_5A5A);
    pulse_start();
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h01); send_byte(8'h00);
    send_word("r1", 8'h5A, 8'h5A);
    check("r1_done", 32'(cur_done), 32'd1);
    idle(1);
    frame_end("r1");

    // Bytes while idle are ignored.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("i_st", 32'(cur_state), 32'(IDLE));
    check("i_busy", 32'(cur_busy), 32'd0);
    idle(2);
    frame_end("i");
    check("i_left12", exp12_q.size(), 0);
    check("i_extra12", extra12, 0);
    check("hdr_len", HDR_BYTES, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
